// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions: R-type function codes (ALU and multiply/divide),
// HI/LO width and the multiply/divide FSM encoding.
package muldiv_unit_pkg;

  localparam int CPU_NB_REG   = 32;
  localparam int CPU_NB_FCODE = 6;
  localparam int MD_CNT_W     = 6;

  // ALU function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

  // Multiply/divide function codes
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  function automatic logic op_is_signed(input md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One iteration of the unsigned multiply (shift-add) or restoring divide
// (shift-subtract). The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int NB_REG = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic              is_div_i,
`endif
  input  logic [NB_REG-1:0] operand_i,
  input  logic [NB_REG-1:0] hi_i,
  input  logic [NB_REG-1:0] lo_i,
  output logic [NB_REG-1:0] hi_o,
  output logic [NB_REG-1:0] lo_o
);

  logic [NB_REG:0] sum;
`ifdef MULDIV_DIV_EN
  logic [NB_REG:0] shifted;
  logic [NB_REG:0] diff;
`endif

  always_comb begin
    // Multiply: {hi,lo} holds partial product above the remaining multiplier bits.
    sum = {1'b0, hi_i} + {1'b0, operand_i};
    if (lo_i[0]) begin
      {hi_o, lo_o} = {sum, lo_i[NB_REG-1:1]};
    end else begin
      {hi_o, lo_o} = {1'b0, hi_i, lo_i[NB_REG-1:1]};
    end
`ifdef MULDIV_DIV_EN
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    shifted = {hi_i, lo_i[NB_REG-1]};
    diff    = shifted - {1'b0, operand_i};
    if (is_div_i) begin
      if (!diff[NB_REG]) begin
        hi_o = diff[NB_REG-1:0];
        lo_o = {lo_i[NB_REG-2:0], 1'b1};
      end else begin
        hi_o = shifted[NB_REG-1:0];
        lo_o = {lo_i[NB_REG-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit; divide support is built only when
// MULDIV_DIV_EN is defined. Handshake: i_start is taken only in IDLE with a
// supported code; o_busy holds through CALC/FIX; o_done pulses with new HI/LO.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int NB_REG   = CPU_NB_REG,
  parameter int NB_FCODE = CPU_NB_FCODE
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_FCODE-1:0] i_funct_code,
  input  logic [NB_REG-1:0]   i_a,
  input  logic [NB_REG-1:0]   i_b,
  input  logic                i_flush,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_REG-1:0]   o_hi,
  output logic [NB_REG-1:0]   o_lo,
  output logic [1:0]          o_dbg_state
);

  localparam logic [MD_CNT_W-1:0] LAST_STEP = MD_CNT_W'(NB_REG - 1);

  md_state_e             state_q, state_d;
  md_op_e                op_q, op_d, new_op;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_REG-1:0]     a_q, a_d, b_q, b_d;
  logic [NB_REG-1:0]     acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [NB_REG-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                  done_q, done_d;
  logic                  new_ok, sgn, neg_res;
  logic [NB_REG-1:0]     a_mag, b_mag, step_operand, init_lo;
  logic [NB_REG-1:0]     step_hi_in, step_lo_in, step_hi, step_lo;
  logic [2*NB_REG-1:0]   prod, prod_fix;
`ifdef MULDIV_DIV_EN
  logic                  is_div;
`endif

  always_comb begin
    new_ok = 1'b0;
    new_op = OP_MULT;
    case (i_funct_code)
      NB_FCODE'(FN_MULT):  begin new_ok = 1'b1; new_op = OP_MULT;  end
      NB_FCODE'(FN_MULTU): begin new_ok = 1'b1; new_op = OP_MULTU; end
`ifdef MULDIV_DIV_EN
      NB_FCODE'(FN_DIV):   begin new_ok = 1'b1; new_op = OP_DIV;   end
      NB_FCODE'(FN_DIVU):  begin new_ok = 1'b1; new_op = OP_DIVU;  end
`endif
      default: ;
    endcase
  end

  assign sgn      = op_is_signed(op_q);
  assign neg_res  = sgn & (a_q[NB_REG-1] ^ b_q[NB_REG-1]);
  assign a_mag    = (sgn && a_q[NB_REG-1]) ? -a_q : a_q;
  assign b_mag    = (sgn && b_q[NB_REG-1]) ? -b_q : b_q;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res ? -prod : prod;

`ifdef MULDIV_DIV_EN
  assign is_div       = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign step_operand = is_div ? b_mag : a_mag;
  assign init_lo      = is_div ? a_mag : b_mag;
`else
  assign step_operand = a_mag;
  assign init_lo      = b_mag;
`endif

  // The first step seeds the accumulator from the latched operands.
  assign step_hi_in = (cnt_q == '0) ? '0 : acc_hi_q;
  assign step_lo_in = (cnt_q == '0) ? init_lo : acc_lo_q;

  muldiv_step #(.NB_REG(NB_REG)) u_step (
`ifdef MULDIV_DIV_EN
    .is_div_i  (is_div),
`endif
    .operand_i (step_operand),
    .hi_i      (step_hi_in),
    .lo_i      (step_lo_in),
    .hi_o      (step_hi),
    .lo_o      (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_flush && new_ok) begin
          a_d     = i_a;
          b_d     = i_b;
          op_d    = new_op;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!i_flush) begin
          done_d = 1'b1;
          hi_d   = prod_fix[2*NB_REG-1:NB_REG];
          lo_d   = prod_fix[NB_REG-1:0];
`ifdef MULDIV_DIV_EN
          if (is_div) begin
            if (b_q == '0) begin
              hi_d = a_q;
              lo_d = '1;
            end else begin
              // Quotient follows the sign product, remainder follows the dividend.
              lo_d = neg_res ? -acc_lo_q : acc_lo_q;
              hi_d = (sgn && a_q[NB_REG-1]) ? -acc_hi_q : acc_hi_q;
            end
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;
  assign o_hi        = hi_q;
  assign o_lo        = lo_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus back-to-back, flush,
// start-while-busy and reset-mid-operation sequences.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W  = 32;
  localparam int NV = 12;
  localparam int LAT  = W + 2;  // edges counted inclusive of the accept edge
  localparam int BUSY = W + 1;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_OK = 1'b1;
`else
  localparam bit DIV_OK = 1'b0;
`endif

  logic         i_clock = 1'b0;
  logic         i_reset, i_start, i_flush;
  logic [5:0]   i_funct_code;
  logic [W-1:0] i_a, i_b;
  logic         o_busy, o_done;
  logic [W-1:0] o_hi, o_lo;
  logic [1:0]   o_dbg_state;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           ok;
  } vec_t;

  vec_t           vecs[NV];
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] e;
  logic [W-1:0]   prev_hi, prev_lo;
  int             errors = 0;
  int             checks = 0;
  int             done_cnt = 0;
  int             lat, busy_n, d0;
  bit             seen;

  muldiv_unit #(.NB_REG(W), .NB_FCODE(6)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_funct_code (i_funct_code),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_flush      (i_flush),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_hi         (o_hi),
    .o_lo         (o_lo),
    .o_dbg_state  (o_dbg_state)
  );

  // clock and watchdog
  always #5 i_clock = ~i_clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  always @(posedge i_clock) if (o_done) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where o_done is seen (or timeout).
  task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat_o, output int busy_o, output bit seen_o);
    i_start = 1'b1; i_funct_code = f; i_a = a; i_b = b;
    @(negedge i_clock);
    i_start = 1'b0;
    lat_o  = 1;
    busy_o = o_busy ? 1 : 0;
    while (!o_done && lat_o < 200) begin
      @(negedge i_clock);
      lat_o++;
      if (o_busy) busy_o++;
    end
    seen_o = o_done;
  endtask

  task automatic do_ignored(input string name, input logic [5:0] f,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    i_start = 1'b1; i_funct_code = f; i_a = a; i_b = b;
    @(negedge i_clock);
    i_start = 1'b0;
    chk({name, "_busy0"}, 64'(o_busy), 64'd0);
    chk({name, "_state"}, 64'(o_dbg_state), 64'(ST_IDLE));
    repeat (3) @(negedge i_clock);
    chk({name, "_busy3"}, 64'(o_busy), 64'd0);
    chk({name, "_hi"}, 64'(o_hi), 64'(prev_hi));
    chk({name, "_lo"}, 64'(o_lo), 64'(prev_lo));
  endtask

  initial begin
    vecs[0]  = '{FN_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b1};
    vecs[1]  = '{FN_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1};
    vecs[2]  = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1};
    vecs[3]  = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1};
    vecs[4]  = '{FN_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1};
    vecs[5]  = '{FN_MULT,  32'h00003039, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7, 1'b1};
    vecs[6]  = '{FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_OK};
    vecs[7]  = '{FN_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, DIV_OK};
    vecs[8]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_OK};
    vecs[9]  = '{FN_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_OK};
    vecs[10] = '{FN_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, DIV_OK};
    vecs[11] = '{FN_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, DIV_OK};

    i_reset = 1'b1; i_start = 1'b0; i_flush = 1'b0;
    i_funct_code = '0; i_a = '0; i_b = '0;
    repeat (3) @(negedge i_clock);
    chk("rst_busy",  64'(o_busy), 64'd0);
    chk("rst_done",  64'(o_done), 64'd0);
    chk("rst_hi",    64'(o_hi), 64'd0);
    chk("rst_lo",    64'(o_lo), 64'd0);
    chk("rst_state", 64'(o_dbg_state), 64'(ST_IDLE));
    i_reset = 1'b0;
    @(negedge i_clock);
    prev_hi = '0; prev_lo = '0;

    // vector table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].ok) begin
        exp_q.push_back({vecs[i].hi, vecs[i].lo});
        do_op(vecs[i].f, vecs[i].a, vecs[i].b, lat, busy_n, seen);
        chk($sformatf("vec%0d_done", i), 64'(seen), 64'd1);
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
        chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'(BUSY));
        chk($sformatf("vec%0d_busy_at_done", i), 64'(o_busy), 64'd0);
        e = exp_q.pop_front();
        chk($sformatf("vec%0d_hi", i), 64'(o_hi), 64'(e[2*W-1:W]));
        chk($sformatf("vec%0d_lo", i), 64'(o_lo), 64'(e[W-1:0]));
        prev_hi = e[2*W-1:W]; prev_lo = e[W-1:0];
        @(negedge i_clock);
        chk($sformatf("vec%0d_done_pulse", i), 64'(o_done), 64'd0);
        chk($sformatf("vec%0d_hold_hi", i), 64'(o_hi), 64'(prev_hi));
        chk($sformatf("vec%0d_hold_lo", i), 64'(o_lo), 64'(prev_lo));
      end else begin
        do_ignored($sformatf("vec%0d_ignored", i), vecs[i].f, vecs[i].a, vecs[i].b);
      end
    end

    // back-to-back: second start lands on the o_done cycle
    do_op(FN_MULTU, 32'd6, 32'd7, lat, busy_n, seen);
    chk("b2b_first_done", 64'(seen), 64'd1);
    chk("b2b_first_hi", 64'(o_hi), 64'd0);
    chk("b2b_first_lo", 64'(o_lo), 64'd42);
    prev_hi = 32'd0; prev_lo = 32'd42;
`ifdef MULDIV_DIV_EN
    do_op(FN_DIVU, 32'd7, 32'd2, lat, busy_n, seen);
    chk("b2b_second_done", 64'(seen), 64'd1);
    chk("b2b_second_latency", 64'(lat), 64'(LAT));
    chk("b2b_second_busy", 64'(busy_n), 64'(BUSY));
    chk("b2b_second_hi", 64'(o_hi), 64'd1);
    chk("b2b_second_lo", 64'(o_lo), 64'd3);
    prev_hi = 32'd1; prev_lo = 32'd3;
`else
    do_ignored("b2b_divu_ignored", FN_DIVU, 32'd7, 32'd2);
`endif
    @(negedge i_clock);

    // flush at cycle 10 with start pulses during CALC
    i_start = 1'b1; i_funct_code = FN_MULTU; i_a = 32'h1234; i_b = 32'h1000;
    @(negedge i_clock);
    for (int k = 1; k < 10; k++) begin
      i_start = (k % 3 == 0); i_funct_code = FN_MULTU; i_a = 32'd5; i_b = 32'd5;
      @(negedge i_clock);
    end
    i_start = 1'b0;
    chk("flush_busy_before", 64'(o_busy), 64'd1);
    d0 = done_cnt;
    i_flush = 1'b1;
    @(negedge i_clock);
    i_flush = 1'b0;
    chk("flush_busy_after", 64'(o_busy), 64'd0);
    chk("flush_state", 64'(o_dbg_state), 64'(ST_IDLE));
    repeat (45) @(negedge i_clock);
    chk("flush_no_done", 64'(done_cnt), 64'(d0));
    chk("flush_hi_kept", 64'(o_hi), 64'(prev_hi));
    chk("flush_lo_kept", 64'(o_lo), 64'(prev_lo));
    i_start = 1'b1; i_flush = 1'b1; i_funct_code = FN_MULTU; i_a = 32'd2; i_b = 32'd3;
    @(negedge i_clock);
    i_start = 1'b0; i_flush = 1'b0;
    chk("flush_beats_start", 64'(o_busy), 64'd0);
    do_op(FN_MULTU, 32'd2, 32'd3, lat, busy_n, seen);
    chk("post_flush_done", 64'(seen), 64'd1);
    chk("post_flush_hi", 64'(o_hi), 64'd0);
    chk("post_flush_lo", 64'(o_lo), 64'd6);
    @(negedge i_clock);

    // start pulses while busy must not disturb the running MULT
    i_start = 1'b1; i_funct_code = FN_MULT; i_a = 32'hFFFFFFFD; i_b = 32'd7;
    @(negedge i_clock);
    lat = 1;
    while (!o_done && lat < 200) begin
      i_start = (lat == 5 || lat == 20); i_funct_code = FN_MULTU; i_a = 32'd2; i_b = 32'd2;
      @(negedge i_clock);
      lat++;
    end
    i_start = 1'b0;
    chk("busy_start_latency", 64'(lat), 64'(LAT));
    chk("busy_start_hi", 64'(o_hi), 64'hFFFFFFFF);
    chk("busy_start_lo", 64'(o_lo), 64'hFFFFFFEB);
    @(negedge i_clock);
    chk("busy_start_not_queued", 64'(o_busy), 64'd0);

    // asynchronous reset in the middle of CALC
    i_start = 1'b1; i_funct_code = FN_MULTU; i_a = 32'hFFFFFFFF; i_b = 32'hFFFFFFFF;
    @(negedge i_clock);
    i_start = 1'b0;
    repeat (8) @(negedge i_clock);
    chk("rst_mid_busy_before", 64'(o_busy), 64'd1);
    #2 i_reset = 1'b1;
    #1;
    chk("rst_mid_hi", 64'(o_hi), 64'd0);
    chk("rst_mid_lo", 64'(o_lo), 64'd0);
    chk("rst_mid_busy", 64'(o_busy), 64'd0);
    chk("rst_mid_state", 64'(o_dbg_state), 64'(ST_IDLE));
    @(negedge i_clock);
    i_reset = 1'b0;
    d0 = done_cnt;
    repeat (40) @(negedge i_clock);
    chk("rst_mid_no_done", 64'(done_cnt), 64'(d0));
    prev_hi = '0; prev_lo = '0;
    do_ignored("funct_0x20", FN_ADD, 32'd1, 32'd2);
    repeat (40) @(negedge i_clock);
    chk("funct_0x20_no_done", 64'(done_cnt), 64'(d0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
